button_repeat: RTL and testbench

- Consumer end of the debounced button interface. Takes the clean button levels from the per-button debouncers and turns them into single-cycle game events for the Tetris game logic.
- Events produced per button: a press pulse, delayed-auto-shift (DAS) repeat pulses while the button is held, a release pulse, and a registered held level.
- Sits between the debouncer bank and the game FSM. The game logic never sees raw levels.
- All buttons are handled identically and independently. Repeat is enabled per channel, so rotate does not auto-repeat.

---
 rtl/button_repeat.sv | 118 +++++++++++
 tb/tb_button_repeat.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/button_repeat.sv
// Turns debounced button levels into single-cycle press/repeat/release events
// for the game logic. Each channel runs its own small FSM and DAS counter.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | button released, waiting for a rising edge
// DELAY  | pressed, counting toward the first auto-repeat
// REPEAT | auto-repeating, counting between repeat pulses
// HOLD   | pressed on a non-repeating channel, waiting for release
module button_repeat #(
    parameter int                     NUM_BUTTONS   = 4,
    parameter int                     DELAY_CYCLES  = 25245000,
    parameter int                     REPEAT_CYCLES = 7425000,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK   = 4'b0111
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    output logic [NUM_BUTTONS-1:0] press_out,
    output logic [NUM_BUTTONS-1:0] release_out,
    output logic [NUM_BUTTONS-1:0] held_out
);

    localparam int MAX_CYCLES = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] DELAY_CNT  = CW'(DELAY_CYCLES);
    localparam logic [CW-1:0] REPEAT_CNT = CW'(REPEAT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                 state_q [NUM_BUTTONS];
    logic [CW-1:0]          cnt_q   [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] prev_q;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] fall;

    assign rise = btn_in & ~prev_q;
    assign fall = ~btn_in & prev_q;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            // Loading prev from btn_in keeps a button held through reset silent.
            press_out   <= '0;
            release_out <= '0;
            held_out    <= btn_in;
            prev_q      <= btn_in;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            held_out <= btn_in;
            prev_q   <= btn_in;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                press_out[i]   <= 1'b0;
                release_out[i] <= 1'b0;
                case (state_q[i])
                    IDLE: begin
                        if (rise[i]) begin
                            press_out[i] <= 1'b1;
                            cnt_q[i]     <= CNT_ONE;
                            state_q[i]   <= REPEAT_MASK[i] ? DELAY : HOLD;
                        end
                    end
                    DELAY: begin
                        if (fall[i]) begin
                            release_out[i] <= 1'b1;
                            cnt_q[i]       <= '0;
                            state_q[i]     <= IDLE;
                        end else if (btn_in[i]) begin
                            if (cnt_q[i] == DELAY_CNT) begin
                                press_out[i] <= 1'b1;
                                cnt_q[i]     <= CNT_ONE;
                                state_q[i]   <= REPEAT;
                            end else if (cnt_q[i] != '1) begin
                                cnt_q[i] <= cnt_q[i] + CNT_ONE;
                            end
                        end
                    end
                    REPEAT: begin
                        // A fall on the same edge as a repeat match takes priority.
                        if (fall[i]) begin
                            release_out[i] <= 1'b1;
                            cnt_q[i]       <= '0;
                            state_q[i]     <= IDLE;
                        end else if (btn_in[i]) begin
                            if (cnt_q[i] == REPEAT_CNT) begin
                                press_out[i] <= 1'b1;
                                cnt_q[i]     <= CNT_ONE;
                            end else if (cnt_q[i] != '1) begin
                                cnt_q[i] <= cnt_q[i] + CNT_ONE;
                            end
                        end
                    end
                    HOLD: begin
                        if (fall[i]) begin
                            release_out[i] <= 1'b1;
                            cnt_q[i]       <= '0;
                            state_q[i]     <= IDLE;
                        end
                    end
                    default: begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_repeat.sv
// Directed bench for button_repeat with short DAS timing (delay 10, repeat 4).
// Expected pulse positions are hand-derived edge offsets from each press.
module tb_button_repeat;

    localparam int NB = 4;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] press_out;
    logic [NB-1:0] release_out;
    logic [NB-1:0] held_out;

    int total = 0;
    int bad   = 0;

    logic [NB-1:0] exp_p;
    logic [NB-1:0] exp_r;
    logic [NB-1:0] btn_seen;

    button_repeat #(
        .NUM_BUTTONS  (NB),
        .DELAY_CYCLES (10),
        .REPEAT_CYCLES(4),
        .REPEAT_MASK  (4'b0111)
    ) dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .btn_in     (btn_in),
        .press_out  (press_out),
        .release_out(release_out),
        .held_out   (held_out)
    );

    always #5 clk_in = ~clk_in;

    // Advance one rising edge, then sample 1 time unit later.
    task automatic tick();
        btn_seen = btn_in;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input int step, input logic [NB-1:0] obs,
                         input logic [NB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%b expected=%b", tag, step, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int step);
        check({tag, "_press"},   step, press_out,   exp_p);
        check({tag, "_release"}, step, release_out, exp_r);
        check({tag, "_held"},    step, held_out,    btn_seen);
    endtask

    initial begin
        reset_in = 1'b1;
        btn_in   = '0;

        // 1: reset, then a long hold on channel 0
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_p = '0; exp_r = '0;
            check_all("t1_reset", k);
        end
        reset_in = 1'b0;
        tick();
        for (int k = 0; k <= 26; k++) begin
            btn_in[0] = (k <= 24);
            tick();
            exp_p = {3'b000, (k == 0 || k == 10 || k == 14 || k == 18 || k == 22)};
            exp_r = {3'b000, (k == 25)};
            check_all("t1", k);
        end

        // 2: release on the edge where a repeat would fire
        for (int k = 0; k <= 27; k++) begin
            btn_in[1] = (k <= 25);
            tick();
            exp_p = {2'b00, (k == 0 || k == 10 || k == 14 || k == 18 || k == 22), 1'b0};
            exp_r = {2'b00, (k == 26), 1'b0};
            check_all("t2", k);
        end

        // 3: rotate channel never repeats
        for (int k = 0; k <= 41; k++) begin
            btn_in[3] = (k <= 39);
            tick();
            exp_p = {(k == 0), 3'b000};
            exp_r = {(k == 40), 3'b000};
            check_all("t3", k);
        end

        // 4: held through reset stays silent until seen low then high
        btn_in[2] = 1'b1;
        reset_in  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_p = '0; exp_r = '0;
            check_all("t4_reset", k);
        end
        reset_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_all("t4_hold", k);
        end
        btn_in[2] = 1'b0;
        tick();
        check_all("t4_release", 0);
        for (int k = 0; k <= 13; k++) begin
            btn_in[2] = (k <= 11);
            tick();
            exp_p = {1'b0, (k == 0 || k == 10), 2'b00};
            exp_r = {1'b0, (k == 12), 2'b00};
            check_all("t4_repress", k);
        end

        // 5: reset mid-hold aborts, channel silent until re-pressed
        for (int k = 0; k <= 25; k++) begin
            btn_in[0] = (k < 20) || (k == 22);
            reset_in  = (k == 12);
            tick();
            exp_p = {3'b000, (k == 0 || k == 10 || k == 22)};
            exp_r = {3'b000, (k == 23)};
            check_all("t5", k);
        end
        reset_in = 1'b0;

        // 6: two channels pressed together, one released early
        for (int k = 0; k <= 17; k++) begin
            btn_in[0] = (k <= 15);
            btn_in[1] = (k <= 4);
            tick();
            exp_p = {2'b00, (k == 0), (k == 0 || k == 10 || k == 14)};
            exp_r = {2'b00, (k == 5), (k == 16)};
            check_all("t6", k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
